// File: rtl/rca_mul_pkg.sv
// Shared types for the shift-and-add multiplier controller: FSM state encoding
// and counter-width helpers.
package rca_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int N_DEFAULT = 8;
   localparam int CNT_W     = $clog2(N_DEFAULT + 1);

   // The counter must hold 0..N, so its width follows the operand width.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rca_Nbits.sv
// N-bit ripple-carry adder: the single adder shared by the multiplier datapath.
module rca_Nbits #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < N; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[N];
   end

endmodule

// File: rtl/rca_shift_add_mul_ctrl.sv
// Sequential unsigned shift-and-add multiplier reusing one rca_Nbits over N cycles.
// Optional macro RCA_MUL_EARLY_TERM_EN finishes early once the remaining multiplier bits are zero.
module rca_shift_add_mul_ctrl
   import rca_mul_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_valid,
   output logic           start_ready,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   state_t state, state_next;

   logic [N-1:0]   mcand;
   logic [2*N-1:0] p;
   logic [2*N-1:0] p_next;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   addend;
   logic [N-1:0]   sum;
   logic           carry;
   logic           calc_end;

   assign addend = p[0] ? mcand : '0;

   rca_Nbits #(.N(N)) u_adder (
      .a    (p[2*N-1:N]),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (carry)
   );

`ifdef RCA_MUL_EARLY_TERM_EN
   logic [N-1:0]  remain_mask;
   logic [CW-1:0] shift_amt;
   logic          early;

   // Once the unconsumed multiplier bits are all zero, every remaining step is a
   // pure right shift, so the whole alignment is applied at once.
   always_comb begin
      remain_mask = {N{1'b1}} >> cnt;
      shift_amt   = CW'(N) - cnt;
      early       = ((p[N-1:0] & remain_mask) == '0);
      p_next      = early ? (p >> shift_amt) : {carry, sum, p[N-1:1]};
      calc_end    = early || (cnt == LAST_CNT);
   end
`else
   always_comb begin
      p_next   = {carry, sum, p[N-1:1]};
      calc_end = (cnt == LAST_CNT);
   end
`endif

   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);
   assign busy        = (state != IDLE);

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_valid) state_next = CALC;
         CALC:    if (calc_end)    state_next = DONE;
         DONE:    if (res_ready)   state_next = IDLE;
         default:                  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mcand   <= '0;
         p       <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         state <= state_next;
         unique case (state)
            IDLE: begin
               if (start_valid) begin
                  mcand <= a_in;
                  p     <= {{N{1'b0}}, b_in};
                  cnt   <= '0;
               end
            end
            CALC: begin
               p   <= p_next;
               cnt <= cnt + CW'(1);
               if (calc_end) product <= p_next;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
